// File: rtl/div_clock_monitor.sv
// div_clock_monitor
// Receives a ripple-divided clock in the fast `clock` domain. It turns each
// rising edge into a one-cycle `edge_tick` enable and measures the divided
// period in `clock` cycles. It declares lock after a run of in-tolerance
// periods and flags a timeout when the divided clock stops toggling.
// `reset` is asynchronous and active-low.

module div_clock_monitor #(
    parameter int EXPECTED_PERIOD = 131072,
    parameter int TOLERANCE       = 2,
    parameter int LOCK_COUNT      = 4,
    parameter int COUNT_WIDTH     = 18
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   div_clock,
    output logic                   edge_tick,
    output logic [COUNT_WIDTH-1:0] period,
    output logic                   period_valid,
    output logic                   locked,
    output logic                   timeout
);

    localparam logic [COUNT_WIDTH-1:0] PERIOD_HI = COUNT_WIDTH'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [COUNT_WIDTH-1:0] PERIOD_LO = COUNT_WIDTH'(EXPECTED_PERIOD - TOLERANCE);
    localparam int                     GOOD_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0]      LOCK_TARGET = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     sync1;
    logic                     sync2;
    logic                     sync3;
    logic [COUNT_WIDTH-1:0]   cnt;
    logic [COUNT_WIDTH-1:0]   cnt_next;
    logic [GOOD_W-1:0]        good_cnt;
    logic [GOOD_W-1:0]        good_next;
    logic [GOOD_W-1:0]        good_inc;
    logic [COUNT_WIDTH-1:0]   measured;
    logic [COUNT_WIDTH-1:0]   period_next;
    logic                     valid_next;
    logic                     timeout_next;
    logic                     in_tol;
    logic                     timeout_hit;

    // Three-flop synchronizer; the third flop only feeds the edge detector
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= div_clock;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_tick = sync2 & ~sync3;

    // Period classification and timeout detection for the current cycle
    always_comb begin
        measured    = cnt + 1'b1;
        in_tol      = (measured >= PERIOD_LO) && (measured <= PERIOD_HI);
        good_inc    = (good_cnt == LOCK_TARGET) ? good_cnt : good_cnt + 1'b1;
        timeout_hit = (state != IDLE) && !edge_tick && (cnt == PERIOD_HI);
    end

    // State register together with the registered datapath and outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            good_cnt     <= good_next;
            period       <= period_next;
            period_valid <= valid_next;
            locked       <= (state_next == LOCKED);
            timeout      <= timeout_next;
        end
    end

    // Next-state logic; an edge always takes priority over a timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (edge_tick) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (edge_tick) begin
                    if (in_tol && (good_inc == LOCK_TARGET)) begin
                        state_next = LOCKED;
                    end
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            LOCKED: begin
                if (edge_tick) begin
                    if (!in_tol) begin
                        state_next = MEASURE;
                    end
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values: counter, good-period run, period report, timeout
    always_comb begin
        cnt_next     = cnt;
        good_next    = good_cnt;
        period_next  = period;
        valid_next   = 1'b0;
        timeout_next = 1'b0;
        case (state)
            MEASURE, LOCKED: begin
                if (edge_tick) begin
                    cnt_next    = '0;
                    period_next = measured;
                    valid_next  = 1'b1;
                    good_next   = in_tol ? good_inc : '0;
                end else if (timeout_hit) begin
                    cnt_next     = '0;
                    good_next    = '0;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                cnt_next  = '0;
                good_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_div_clock_monitor.sv
// tb_div_clock_monitor
// Drives div_clock_monitor with directed period tables, hand-built corner
// sequences and random divided-clock waveforms. An event-level model tracks
// edge times and good-period runs and is compared against every output every
// half cycle.

module tb_div_clock_monitor;

    localparam int EP = 8;
    localparam int TOL = 1;
    localparam int LC = 3;
    localparam int CW = 8;

    logic          clock;
    logic          reset;
    logic          div_clock;
    logic          edge_tick;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          timeout;

    int total = 0;
    int bad = 0;

    // Reference model state: edge times in cycles and the run of good periods
    int       cycle_no = 0;
    bit       tracking;
    int       last_edge;
    int       good_run;
    bit       hist[$];
    bit       m_tick;
    bit [7:0] m_period;
    bit       m_valid;
    bit       m_locked;
    bit       m_timeout;

    typedef struct {
        int       len;
        int       exp_pv;
        bit [7:0] exp_period;
        bit       exp_locked;
    } vec_t;

    vec_t vecs [13];

    int       pv_cnt;
    int       to_cnt;
    bit [7:0] last_per;
    bit       last_lock;
    int       tick_step;
    int       to_step;
    int       h_len;
    int       s_len;
    int       rst_at;

    div_clock_monitor #(
        .EXPECTED_PERIOD(EP),
        .TOLERANCE(TOL),
        .LOCK_COUNT(LC),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .div_clock(div_clock),
        .edge_tick(edge_tick),
        .period(period),
        .period_valid(period_valid),
        .locked(locked),
        .timeout(timeout)
    );

    // Free-running system clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        tracking  = 1'b0;
        last_edge = 0;
        good_run  = 0;
        m_tick    = 1'b0;
        m_period  = '0;
        m_valid   = 1'b0;
        m_locked  = 1'b0;
        m_timeout = 1'b0;
        hist      = '{1'b0, 1'b0, 1'b0};
    endtask

    // One rising clock edge: resolve the cycle that just ended, then sample
    task automatic modelEdge(input bit div_val);
        int c;
        int p;
        c = cycle_no;
        cycle_no++;
        m_valid   = 1'b0;
        m_timeout = 1'b0;
        if (m_tick) begin
            if (!tracking) begin
                tracking  = 1'b1;
                last_edge = c;
            end else begin
                p         = c - last_edge;
                last_edge = c;
                m_period  = 8'(p);
                m_valid   = 1'b1;
                if (p >= EP - TOL && p <= EP + TOL) good_run = (good_run < LC) ? good_run + 1 : LC;
                else good_run = 0;
            end
        end else if (tracking && (c - last_edge == EP + TOL + 1)) begin
            tracking  = 1'b0;
            good_run  = 0;
            m_timeout = 1'b1;
        end
        m_locked = tracking && (good_run == LC);
        hist.push_front(div_val);
        void'(hist.pop_back());
        m_tick = hist[1] & ~hist[2];
    endtask

    task automatic checkOutput();
        compareVal("edge_tick", 32'(edge_tick), 32'(m_tick));
        compareVal("period", 32'(period), 32'(m_period));
        compareVal("period_valid", 32'(period_valid), 32'(m_valid));
        compareVal("locked", 32'(locked), 32'(m_locked));
        compareVal("timeout", 32'(timeout), 32'(m_timeout));
    endtask

    // Drive inputs on the falling edge, check there and just after the rising edge
    task automatic applyStimulus(input bit div_val, input bit rst_val);
        @(negedge clock);
        div_clock = div_val;
        reset     = rst_val;
        if (!rst_val) modelReset();
        #1 checkOutput();
        @(posedge clock);
        if (rst_val) modelEdge(div_val);
        #1 checkOutput();
    endtask

    // One divided-clock period starting with a rising edge, capturing reports
    task automatic runSegment(input int len, input int high_len, output int pvs,
                              output bit [7:0] per, output bit lck, output int tos);
        pvs = 0;
        tos = 0;
        per = '0;
        lck = 1'b0;
        for (int j = 0; j < len; j++) begin
            applyStimulus(j < high_len, 1'b1);
            if (period_valid) begin
                pvs++;
                per = period;
                lck = locked;
            end
            if (timeout) tos++;
        end
    endtask

    initial begin
        vecs[0]  = '{8, 0, 8'd0, 1'b0};
        vecs[1]  = '{8, 1, 8'd8, 1'b0};
        vecs[2]  = '{8, 1, 8'd8, 1'b0};
        vecs[3]  = '{10, 1, 8'd8, 1'b1};
        vecs[4]  = '{8, 1, 8'd10, 1'b0};
        vecs[5]  = '{7, 1, 8'd8, 1'b0};
        vecs[6]  = '{9, 1, 8'd7, 1'b0};
        vecs[7]  = '{8, 1, 8'd9, 1'b1};
        vecs[8]  = '{6, 1, 8'd8, 1'b1};
        vecs[9]  = '{8, 1, 8'd6, 1'b0};
        vecs[10] = '{8, 1, 8'd8, 1'b0};
        vecs[11] = '{8, 1, 8'd8, 1'b0};
        vecs[12] = '{8, 1, 8'd8, 1'b1};

        reset     = 1'b1;
        div_clock = 1'b0;
        modelReset();

        for (int j = 0; j < 10; j++) applyStimulus(((j / 2) % 2) == 1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 1'b1);
            compareVal("idle_after_release", 32'({edge_tick, period_valid, locked, timeout}), 32'd0);
        end

        for (int i = 0; i < 13; i++) begin
            runSegment(vecs[i].len, vecs[i].len / 2, pv_cnt, last_per, last_lock, to_cnt);
            compareVal($sformatf("vec%0d_pv_count", i), 32'(pv_cnt), 32'(vecs[i].exp_pv));
            compareVal($sformatf("vec%0d_timeouts", i), 32'(to_cnt), 32'd0);
            if (vecs[i].exp_pv != 0) begin
                compareVal($sformatf("vec%0d_period", i), 32'(last_per), 32'(vecs[i].exp_period));
                compareVal($sformatf("vec%0d_locked", i), 32'(last_lock), 32'(vecs[i].exp_locked));
            end
        end

        // Stop the divided clock while locked; the decision cycle is 10 cycles
        // after the tick and the registered pulse shows one cycle later
        to_cnt    = 0;
        tick_step = -1;
        to_step   = -1;
        for (int j = 0; j < 24; j++) begin
            applyStimulus(j < 4, 1'b1);
            if (edge_tick) tick_step = j;
            if (timeout) begin
                to_cnt++;
                to_step = j;
            end
        end
        compareVal("timeout_count", 32'(to_cnt), 32'd1);
        compareVal("timeout_delay", 32'(to_step - tick_step), 32'(EP + TOL + 2));
        compareVal("timeout_locked", 32'(locked), 32'd0);
        compareVal("timeout_period_kept", 32'(period), 32'd8);

        runSegment(8, 4, pv_cnt, last_per, last_lock, to_cnt);
        compareVal("reacquire_first_pv", 32'(pv_cnt), 32'd0);
        for (int i = 0; i < 3; i++) runSegment(8, 4, pv_cnt, last_per, last_lock, to_cnt);
        compareVal("reacquire_locked", 32'(last_lock), 32'd1);

        for (int j = 0; j < 8; j++) begin
            applyStimulus(j < 4, j != 5);
            if (j == 5) begin
                compareVal("midlock_reset_locked", 32'(locked), 32'd0);
                compareVal("midlock_reset_period", 32'(period), 32'd0);
            end
        end
        runSegment(8, 4, pv_cnt, last_per, last_lock, to_cnt);
        compareVal("post_reset_first_pv", 32'(pv_cnt), 32'd0);
        runSegment(8, 4, pv_cnt, last_per, last_lock, to_cnt);
        compareVal("post_reset_second_pv", 32'(pv_cnt), 32'd1);
        compareVal("post_reset_period", 32'(last_per), 32'd8);

        // Random periods, high widths down to one cycle, and occasional resets
        for (int i = 0; i < 300; i++) begin
            s_len  = int'($urandom_range(5, 14));
            h_len  = int'($urandom_range(1, s_len - 1));
            rst_at = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, s_len - 1)) : -1;
            for (int j = 0; j < s_len; j++) applyStimulus(j < h_len, j != rst_at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
